// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU program sequencer: opcodes, error codes,
// FSM states and instruction field layout.
package stack_alu_pkg;

    localparam int OP_W  = 3;
    localparam int ERR_W = 2;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_PUSH = 3'b110;
    localparam logic [OP_W-1:0] OP_POP  = 3'b111;

    localparam logic [ERR_W-1:0] ERR_NONE      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [ERR_W-1:0] ERR_FULL      = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL   = 2'b11;

    // Instruction word is {op, imm}: imm occupies [n-1:0], op sits directly above it.
    function automatic int instr_width(input int n);
        return n + OP_W;
    endfunction

    function automatic int op_lsb(input int n);
        return n;
    endfunction

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DRAIN,
        ST_DRAIN_WAIT,
        ST_FIN
    } seq_state_t;

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Bus between the sequencer and one stack ALU instance.
interface stack_alu_sequencer_if
    import stack_alu_pkg::*;
#(
    parameter int N = 32
);
    logic [OP_W-1:0] alu_opcode;
    logic [N-1:0]    alu_data;
    logic [N-1:0]    alu_result;
    logic            alu_overflow;

    modport master (
        output alu_opcode,
        output alu_data,
        input  alu_result,
        input  alu_overflow
    );

    modport slave (
        input  alu_opcode,
        input  alu_data,
        output alu_result,
        output alu_overflow
    );
endinterface

// File: rtl/seq_prog_mem.sv
// Program store: one write port, one registered read port; maps onto block RAM.
module seq_prog_mem #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // Write-before-read is not needed: a write and the following fetch are
    // always at least one cycle apart.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/stack_alu_sequencer.sv
// Runs a host-loaded program through a stack ALU, guarding stack depth before
// each issue and draining the ALU stack when the program ends or aborts.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int N           = 32,
    parameter int PROG_DEPTH  = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [N+OP_W-1:0]             prog_wdata,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [N-1:0]                  result,
    output logic                          ovf,
    output logic                          err,
    output logic [ERR_W-1:0]              err_code,
    stack_alu_sequencer_if.master         alu
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = instr_width(N);

    seq_state_t state_reg, state_next;

    logic [LW-1:0]    pc_reg, len_reg;
    logic [DW-1:0]    depth_reg;
    logic [OP_W-1:0]  op_reg;
    logic [N-1:0]     imm_reg;
    logic             first_drain_reg;
    logic             busy_reg, done_reg, ovf_reg, err_reg;
    logic [ERR_W-1:0] err_code_reg;
    logic [N-1:0]     result_reg;

    logic [IW-1:0]    instr;
    logic [OP_W-1:0]  instr_op;
    logic [N-1:0]     instr_imm;
    logic [ERR_W-1:0] check_code;
    logic             start_ok;
    logic             ram_we, ram_re;
    logic [OP_W-1:0]  alu_op_c;
    logic [N-1:0]     alu_data_c;

    seq_prog_mem #(
        .DATA_W (IW),
        .DEPTH  (PROG_DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .re    (ram_re),
        .raddr (pc_reg[AW-1:0]),
        .rdata (instr)
    );

    // The program cannot be rewritten under a running sequence.
    assign ram_we    = prog_we && !busy_reg;
    assign instr_op  = instr[op_lsb(N) +: OP_W];
    assign instr_imm = instr[N-1:0];

    // A start coinciding with the completion pulse belongs to the old run.
    assign start_ok  = (state_reg == ST_IDLE) && start && !done_reg;

    always_comb begin
        check_code = ERR_NONE;
        if (op_is_illegal(instr_op)) begin
            check_code = ERR_ILLEGAL;
        end else if ((instr_op == OP_PUSH) && (depth_reg == DW'(STACK_DEPTH))) begin
            check_code = ERR_FULL;
        end else if (((instr_op == OP_ADD) || (instr_op == OP_MUL)) && (depth_reg < DW'(2))) begin
            check_code = ERR_UNDERFLOW;
        end else if ((instr_op == OP_POP) && (depth_reg == '0)) begin
            check_code = ERR_UNDERFLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Draining is skipped entirely when the stack is already empty so each
    // drained entry costs exactly two cycles.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = (prog_len == '0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_CHECK;
            ST_CHECK: begin
                if (check_code != ERR_NONE) begin
                    state_next = (depth_reg == '0) ? ST_FIN : ST_DRAIN;
                end else if (instr_op == OP_NOP) begin
                    state_next = ST_NEXT;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_NEXT;
            ST_NEXT: begin
                if (pc_reg == len_reg) begin
                    state_next = (depth_reg == '0) ? ST_FIN : ST_DRAIN;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN:      state_next = ST_DRAIN_WAIT;
            ST_DRAIN_WAIT: state_next = (depth_reg == '0) ? ST_FIN : ST_DRAIN;
            ST_FIN:        state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_op_c   = OP_NOP;
        alu_data_c = '0;
        ram_re     = 1'b0;
        case (state_reg)
            ST_FETCH: ram_re = 1'b1;
            ST_ISSUE: begin
                alu_op_c   = op_reg;
                alu_data_c = imm_reg;
            end
            ST_DRAIN: alu_op_c = OP_POP;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= '0;
            len_reg         <= '0;
            depth_reg       <= '0;
            op_reg          <= OP_NOP;
            imm_reg         <= '0;
            first_drain_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            result_reg      <= '0;
            ovf_reg         <= 1'b0;
            err_reg         <= 1'b0;
            err_code_reg    <= ERR_NONE;
        end else begin
            done_reg <= (state_reg == ST_FIN);
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        busy_reg        <= 1'b1;
                        len_reg         <= prog_len;
                        pc_reg          <= '0;
                        result_reg      <= '0;
                        ovf_reg         <= 1'b0;
                        err_reg         <= 1'b0;
                        err_code_reg    <= ERR_NONE;
                        first_drain_reg <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    op_reg  <= instr_op;
                    imm_reg <= instr_imm;
                    if (check_code != ERR_NONE) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= check_code;
                    end else if (instr_op == OP_NOP) begin
                        pc_reg <= pc_reg + LW'(1);
                    end
                end
                ST_ISSUE: begin
                    if (op_reg == OP_PUSH) begin
                        depth_reg <= depth_reg + DW'(1);
                    end else begin
                        depth_reg <= depth_reg - DW'(1);
                    end
                end
                ST_WAIT: begin
                    if ((op_reg == OP_ADD) || (op_reg == OP_MUL)) begin
                        result_reg <= alu.alu_result;
                        ovf_reg    <= ovf_reg | alu.alu_overflow;
                    end else if (op_reg == OP_POP) begin
                        result_reg <= alu.alu_result;
                    end
                    pc_reg <= pc_reg + LW'(1);
                end
                ST_DRAIN: depth_reg <= depth_reg - DW'(1);
                ST_DRAIN_WAIT: begin
                    if (first_drain_reg) begin
                        result_reg      <= alu.alu_result;
                        first_drain_reg <= 1'b0;
                    end
                end
                ST_FIN: busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign alu.alu_opcode = alu_op_c;
    assign alu.alu_data   = alu_data_c;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign result         = result_reg;
    assign ovf            = ovf_reg;
    assign err            = err_reg;
    assign err_code       = err_code_reg;
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer with a behavioural stack ALU and a queue of
// expected end-of-program results.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int N  = 32;
    localparam int PD = 16;
    localparam int SD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [34:0] prog_wdata;
    logic [4:0]  prog_len;
    logic        start;
    logic        busy, done, ovf, err;
    logic [31:0] result;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    stack_alu_sequencer_if #(.N(N)) bus ();

    stack_alu_sequencer #(
        .N           (N),
        .PROG_DEPTH  (PD),
        .STACK_DEPTH (SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_len   (prog_len),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .ovf        (ovf),
        .err        (err),
        .err_code   (err_code),
        .alu        (bus)
    );

    // Behavioural stack ALU, reset together with the sequencer
    logic [31:0] stk [SD];
    logic [3:0]  alu_sp;
    logic [31:0] alu_res;
    logic        alu_ov;
    int          alu_faults = 0;
    logic [2:0]  idx1, idx2;
    logic [31:0] t0, t1, sum;
    longint      prod;

    always_comb begin
        idx1 = 3'(alu_sp - 4'd1);
        idx2 = 3'(alu_sp - 4'd2);
        t0   = stk[idx1];
        t1   = stk[idx2];
        sum  = t1 + t0;
        prod = longint'($signed(t1)) * longint'($signed(t0));
    end

    always @(posedge clk) begin
        if (rst) begin
            alu_sp  <= '0;
            alu_res <= '0;
            alu_ov  <= 1'b0;
        end else begin
            case (bus.alu_opcode)
                3'b110: begin
                    if (alu_sp >= 4'(SD)) alu_faults <= alu_faults + 1;
                    else begin
                        stk[alu_sp[2:0]] <= bus.alu_data;
                        alu_sp <= alu_sp + 4'd1;
                    end
                end
                3'b100: begin
                    if (alu_sp < 4'd2) alu_faults <= alu_faults + 1;
                    else begin
                        stk[idx2] <= sum;
                        alu_sp    <= alu_sp - 4'd1;
                        alu_res   <= sum;
                        alu_ov    <= (t0[31] == t1[31]) && (sum[31] != t0[31]);
                    end
                end
                3'b101: begin
                    if (alu_sp < 4'd2) alu_faults <= alu_faults + 1;
                    else begin
                        stk[idx2] <= prod[31:0];
                        alu_sp    <= alu_sp - 4'd1;
                        alu_res   <= prod[31:0];
                        alu_ov    <= (prod != longint'($signed(prod[31:0])));
                    end
                end
                3'b111: begin
                    if (alu_sp < 4'd1) alu_faults <= alu_faults + 1;
                    else begin
                        alu_sp  <= alu_sp - 4'd1;
                        alu_res <= t0;
                        alu_ov  <= 1'b0;
                    end
                end
                3'b000: ;
                default: alu_faults <= alu_faults + 1;
            endcase
        end
    end

    assign bus.alu_result   = alu_res;
    assign bus.alu_overflow = alu_ov;

    // Opcode monitor, sampled mid-cycle
    int n_push = 0, n_pop = 0, n_arith = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.alu_opcode == 3'b110) n_push <= n_push + 1;
            if (bus.alu_opcode == 3'b111) n_pop <= n_pop + 1;
            if (bus.alu_opcode == 3'b100 || bus.alu_opcode == 3'b101) n_arith <= n_arith + 1;
        end
    end

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t expq[$];
    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [2:0] op, input logic [31:0] imm);
        prog_we    = 1'b1;
        prog_addr  = 4'(addr);
        prog_wdata = {op, imm};
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic go(input int len);
        prog_len = 5'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic expect_run(input logic [31:0] r, input logic o, input logic e, input logic [1:0] c);
        exp_t x;
        x.result = r;
        x.ovf    = o;
        x.err    = e;
        x.code   = c;
        expq.push_back(x);
    endtask

    // Waits (bounded) for done, then pops and compares the scoreboard entry
    task automatic collect(input int first, output int cyc);
        exp_t x;
        cyc = first;
        while (done !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
            errors++;
        end else if (expq.size() == 0) begin
            $display("FAIL unexpected_done: done with empty scoreboard");
            errors++;
        end else begin
            x = expq.pop_front();
            checks++;
            if (result !== x.result) begin
                $display("FAIL result: got %h want %h", result, x.result); errors++;
            end
            checks++;
            if (ovf !== x.ovf) begin
                $display("FAIL ovf: got %b want %b", ovf, x.ovf); errors++;
            end
            checks++;
            if (err !== x.err || err_code !== x.code) begin
                $display("FAIL err: got %b/%b want %b/%b", err, err_code, x.err, x.code); errors++;
            end
            checks++;
            if (busy !== 1'b0) begin
                $display("FAIL busy_at_done: got %b want 0", busy); errors++;
            end
        end
        $display("run: cycles=%0d result=%h ovf=%b err=%b code=%b", cyc, result, ovf, err, err_code);
    endtask

    task automatic check_run(input string name, input int cyc, input int want_cyc,
                             input int dpush, input int want_push, input int dpop, input int want_pop);
        checks++;
        if (cyc !== want_cyc) begin
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, want_cyc); errors++;
        end
        checks++;
        if (dpush !== want_push || dpop !== want_pop) begin
            $display("FAIL %s_ops: push/pop got %0d/%0d want %0d/%0d", name, dpush, dpop, want_push, want_pop);
            errors++;
        end
        checks++;
        if (alu_sp !== 4'd0) begin
            $display("FAIL %s_drain: alu depth got %0d want 0", name, alu_sp); errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_wdata = '0; prog_len = '0;
        repeat (3) tick();
        checks++;
        if ({busy, done, ovf, err, err_code, bus.alu_opcode} !== 9'd0 || result !== 32'd0 || bus.alu_data !== 32'd0) begin
            $display("FAIL reset_state: busy=%b done=%b ovf=%b err=%b code=%b op=%b result=%h data=%h",
                     busy, done, ovf, err, err_code, bus.alu_opcode, result, bus.alu_data);
            errors++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int cyc, p0, q0, a0;
        load(0, OP_PUSH, 32'd10); load(1, OP_PUSH, 32'd20); load(2, OP_ADD, 32'd0);
        p0 = n_push; q0 = n_pop; a0 = n_arith;
        expect_run(32'd30, 1'b0, 1'b0, ERR_NONE);
        go(3);
        collect(1, cyc);
        check_run("add", cyc, 19, n_push - p0, 2, n_pop - q0, 1);
        checks++;
        if (n_arith - a0 !== 1) begin
            $display("FAIL add_issue: arith count got %0d want 1", n_arith - a0); errors++;
        end
    endtask

    task automatic test_mul();
        int cyc, p0, q0;
        load(0, OP_PUSH, 32'd3); load(1, OP_PUSH, 32'd4);
        load(2, OP_MUL, 32'd0);  load(3, OP_PUSH, 32'd5);
        p0 = n_push; q0 = n_pop;
        expect_run(32'd5, 1'b0, 1'b0, ERR_NONE);
        go(4);
        collect(1, cyc);
        check_run("mul", cyc, 26, n_push - p0, 3, n_pop - q0, 2);
    endtask

    task automatic test_overflow();
        int cyc, p0, q0;
        load(0, OP_PUSH, 32'h7FFF_FFFF); load(1, OP_PUSH, 32'd1); load(2, OP_ADD, 32'd0);
        p0 = n_push; q0 = n_pop;
        expect_run(32'h8000_0000, 1'b1, 1'b0, ERR_NONE);
        go(3);
        collect(1, cyc);
        check_run("ovf", cyc, 19, n_push - p0, 2, n_pop - q0, 1);
        load(0, OP_PUSH, 32'd5); load(1, OP_PUSH, 32'd6);
        expect_run(32'd11, 1'b0, 1'b0, ERR_NONE);
        go(3);
        collect(1, cyc);
        check_run("ovf_clear", cyc, 19, n_push - p0, 4, n_pop - q0, 2);
    endtask

    task automatic test_underflow();
        int cyc, p0, q0, a0;
        load(0, OP_PUSH, 32'd7); load(1, OP_ADD, 32'd0);
        p0 = n_push; q0 = n_pop; a0 = n_arith;
        expect_run(32'd7, 1'b0, 1'b1, ERR_UNDERFLOW);
        go(2);
        collect(1, cyc);
        check_run("underflow", cyc, 11, n_push - p0, 1, n_pop - q0, 1);
        checks++;
        if (n_arith - a0 !== 0) begin
            $display("FAIL underflow_issue: arith count got %0d want 0", n_arith - a0); errors++;
        end
    endtask

    task automatic test_full();
        int cyc, p0, q0;
        for (int i = 0; i < SD + 1; i++) load(i, OP_PUSH, 32'(i + 1));
        p0 = n_push; q0 = n_pop;
        expect_run(32'd8, 1'b0, 1'b1, ERR_FULL);
        go(SD + 1);
        collect(1, cyc);
        check_run("full", cyc, 60, n_push - p0, 8, n_pop - q0, 8);
    endtask

    task automatic test_illegal();
        int cyc, p0, q0;
        load(0, OP_PUSH, 32'd1); load(1, 3'b010, 32'd9);
        p0 = n_push; q0 = n_pop;
        expect_run(32'd1, 1'b0, 1'b1, ERR_ILLEGAL);
        go(2);
        collect(1, cyc);
        check_run("illegal", cyc, 11, n_push - p0, 1, n_pop - q0, 1);
    endtask

    task automatic test_empty();
        int cyc;
        tick();
        expect_run(32'd0, 1'b0, 1'b0, ERR_NONE);
        go(0);
        collect(1, cyc);
        checks++;
        if (cyc !== 2) begin
            $display("FAIL empty_latency: got %0d want 2", cyc); errors++;
        end
    endtask

    task automatic test_reset_mid_run();
        int seen, k, cyc, p0, q0;
        load(0, OP_PUSH, 32'd1); load(1, OP_PUSH, 32'd2); load(2, OP_ADD, 32'd0);
        go(3);
        seen = 0; k = 0;
        while (seen < 2 && k < 40) begin
            if (bus.alu_opcode == OP_PUSH) seen++;
            if (seen < 2) tick();
            k++;
        end
        checks++;
        if (seen !== 2 || busy !== 1'b1) begin
            $display("FAIL midrun_reach: pushes seen %0d busy %b want 2/1", seen, busy); errors++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, ovf, err, err_code, bus.alu_opcode} !== 9'd0 || result !== 32'd0 || bus.alu_data !== 32'd0) begin
            $display("FAIL midrun_reset: busy=%b done=%b ovf=%b err=%b code=%b op=%b result=%h",
                     busy, done, ovf, err, err_code, bus.alu_opcode, result);
            errors++;
        end
        rst = 1'b0;
        tick();
        load(0, OP_PUSH, 32'h1234);
        p0 = n_push; q0 = n_pop;
        expect_run(32'h1234, 1'b0, 1'b0, ERR_NONE);
        go(1);
        collect(1, cyc);
        check_run("after_reset", cyc, 9, n_push - p0, 1, n_pop - q0, 1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        load(0, OP_PUSH, 32'h33);
        expect_run(32'h33, 1'b0, 1'b0, ERR_NONE);
        go(1);
        collect(1, cyc);
        // start in the done cycle must be dropped
        prog_len = 5'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL start_on_done: busy got %b want 0", busy); errors++;
        end
        // write coinciding with start is seen by that run
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = {OP_PUSH, 32'h55};
        prog_len = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        prog_wdata = {OP_PUSH, 32'hAA};
        tick();
        prog_we = 1'b0;
        expect_run(32'h55, 1'b0, 1'b0, ERR_NONE);
        collect(2, cyc);
        checks++;
        if (cyc !== 9) begin
            $display("FAIL b2b_latency: got %0d want 9", cyc); errors++;
        end
        tick();
        expect_run(32'h55, 1'b0, 1'b0, ERR_NONE);
        go(1);
        collect(1, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_overflow();
        test_underflow();
        test_full();
        test_illegal();
        test_empty();
        test_reset_mid_run();
        test_back_to_back();
        checks++;
        if (expq.size() != 0) begin
            $display("FAIL scoreboard_leftover: %0d entries want 0", expq.size()); errors++;
        end
        checks++;
        if (alu_faults != 0) begin
            $display("FAIL alu_misuse: %0d bad ALU operations want 0", alu_faults); errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
